code_fetch_arb: RTL and testbench

- Shares the single code memory read port among all warps of an SM core.
- Per-warp fetch requests are granted round-robin, one outstanding fetch per warp, with a global cap on in-flight reads.
- Read responses are steered back to the owning warp by warp id.
- Per-warp flush discards stale responses after a branch redirect. Sits between the warp fetch units and the code memory interface.

---
 rtl/code_fetch_arb_pkg.sv | 29 ++
 rtl/code_fetch_arb_rr_arbiter.sv | 56 +++++
 rtl/code_fetch_arb.sv | 192 +++++++++++++++++++
 tb/tb_code_fetch_arb.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_fetch_arb_pkg.sv
// -----------------------------------------------------------------------------
// code_fetch_arb_pkg
//   Shared types and defaults for the code-fetch arbiter and its users.
//   Provides the warp-id, code-address and code-data types sized from the
//   global configuration macros, plus the default warp count and the default
//   cap on in-flight code memory reads.
//   No ports (package).
// -----------------------------------------------------------------------------
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`ifndef CODE_MEM_ADDR_WIDTH
`define CODE_MEM_ADDR_WIDTH 32
`endif
`ifndef CODE_MEM_DATA_WIDTH
`define CODE_MEM_DATA_WIDTH 32
`endif

package code_fetch_arb_pkg;

    localparam int WARP_ID_W           = `DEPTH_WARP;
    localparam int DEF_NUM_WARP        = 1 << `DEPTH_WARP;
    localparam int DEF_MAX_OUTSTANDING = 4;

    typedef logic [`DEPTH_WARP-1:0]          wid_t;
    typedef logic [`CODE_MEM_ADDR_WIDTH-1:0] code_addr_t;
    typedef logic [`CODE_MEM_DATA_WIDTH-1:0] code_data_t;

endpackage

// File: rtl/code_fetch_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// code_fetch_arb_rr_arbiter
//   Round-robin arbiter over an N-bit request vector. The winner is the first
//   requester at or after the pointer, wrapping modulo N. When advance is set
//   and a winner exists, the pointer moves to winner+1 (wrapping to 0).
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     req         : request vector
//     advance     : the caller consumed this cycle's grant
//     grant       : one-hot winner (combinational, all-zero if no request)
//     grant_idx   : index of the winner
//     grant_any   : at least one request present
// -----------------------------------------------------------------------------
module code_fetch_arb_rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W-1:0] ptr;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!grant_any && req[(int'(ptr) + i) % N]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'((int'(ptr) + i) % N);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && grant_any) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/code_fetch_arb.sv
// -----------------------------------------------------------------------------
// code_fetch_arb
//   Shares the single code memory read port among all warps of an SM core.
//   Fetch requests are granted round-robin, one outstanding fetch per warp,
//   with a global cap on in-flight reads. Responses are steered back to the
//   owning warp by warp id; a per-warp flush discards the stale response that
//   is still in flight after a branch redirect.
//   Optional build macro: CODE_FETCH_CHECK_EN adds a sticky fetch_err_o that
//   flags spurious responses, response-address mismatches and request
//   instability under backpressure.
//   Ports:
//     clk, rst_n                : clock, asynchronous active-low reset
//     fetch_req_valid_i/addr_i  : per-warp fetch requests (warp w at w*ADDR_W)
//     fetch_req_ready_o         : one-hot grant pulse
//     flush_i                   : per-warp flush of the in-flight response
//     code_mem_ready_i          : code memory accepts a request
//     code_rd_req_*_o           : read request (valid/addr/wid)
//     code_rd_rsp_*_i           : read response (valid/addr/wid/data)
//     fetch_rsp_valid_o/addr_o/data_o : one-hot response to the owning warp
//     fetch_err_o               : sticky protocol error (CODE_FETCH_CHECK_EN)
// -----------------------------------------------------------------------------
module code_fetch_arb
    import code_fetch_arb_pkg::*;
#(
    parameter int NUM_WARP        = DEF_NUM_WARP,
    parameter int ADDR_W          = `CODE_MEM_ADDR_WIDTH,
    parameter int DATA_W          = `CODE_MEM_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_WARP-1:0]        fetch_req_valid_i,
    input  logic [NUM_WARP*ADDR_W-1:0] fetch_req_addr_i,
    output logic [NUM_WARP-1:0]        fetch_req_ready_o,
    input  logic [NUM_WARP-1:0]        flush_i,
    input  logic                       code_mem_ready_i,
    output logic                       code_rd_req_valid_o,
    output logic [ADDR_W-1:0]          code_rd_req_addr_o,
    output wid_t                       code_rd_req_wid_o,
    input  logic                       code_rd_rsp_valid_i,
    input  logic [ADDR_W-1:0]          code_rd_rsp_addr_i,
    input  wid_t                       code_rd_rsp_wid_i,
    input  logic [DATA_W-1:0]          code_rd_rsp_data_i,
`ifdef CODE_FETCH_CHECK_EN
    output logic                       fetch_err_o,
`endif
    output logic [NUM_WARP-1:0]        fetch_rsp_valid_o,
    output logic [ADDR_W-1:0]          fetch_rsp_addr_o,
    output logic [DATA_W-1:0]          fetch_rsp_data_o
);

    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_WARP-1:0] pending;
    logic [NUM_WARP-1:0] drop;
    logic [CNT_W-1:0]    count;

    logic [NUM_WARP-1:0] eligible;
    logic [NUM_WARP-1:0] arb_grant;
    logic [NUM_WARP-1:0] grant_vec;
    logic [NUM_WARP-1:0] rsp_onehot;
    wid_t                arb_idx;
    logic                arb_any;
    logic                can_grant;
    logic                req_xfer;
    logic                rsp_hit;
    logic                rsp_deliver;
    logic [ADDR_W-1:0]   win_addr;

    assign eligible = fetch_req_valid_i & ~pending & ~flush_i;
    assign req_xfer = code_rd_req_valid_o & code_mem_ready_i;

    // The count compare uses the registered value only: a response retiring
    // this cycle frees its slot for the next cycle, not this one.
    assign can_grant = arb_any && (count < CNT_MAX) &&
                       (!code_rd_req_valid_o || code_mem_ready_i);

    assign grant_vec         = can_grant ? arb_grant : '0;
    assign fetch_req_ready_o = grant_vec;
    assign win_addr          = fetch_req_addr_i[arb_idx*ADDR_W +: ADDR_W];

    // A response for a warp that is not pending is spurious (e.g. issued
    // before a reset) and must not touch the count or the pending/drop state.
    assign rsp_hit     = code_rd_rsp_valid_i & pending[code_rd_rsp_wid_i];
    assign rsp_onehot  = rsp_hit ? (NUM_WARP'(1) << code_rd_rsp_wid_i) : '0;
    assign rsp_deliver = rsp_hit & ~drop[code_rd_rsp_wid_i] & ~flush_i[code_rd_rsp_wid_i];

    code_fetch_arb_rr_arbiter #(
        .N     (NUM_WARP),
        .IDX_W ($bits(wid_t))
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (eligible),
        .advance   (can_grant),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Per-warp bookkeeping and the global in-flight count. A flush only marks
    // a warp whose fetch is already in flight; the request itself is never
    // withdrawn, its response is simply dropped on return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            drop    <= '0;
            count   <= '0;
        end else begin
            pending <= (pending & ~rsp_onehot) | grant_vec;
            drop    <= (drop | (flush_i & pending)) & ~rsp_onehot;
            if (can_grant && !rsp_hit) begin
                count <= count + CNT_W'(1);
            end else if (!can_grant && rsp_hit) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Single-entry request register; a new grant may load it in the same
    // cycle the held request transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_rd_req_valid_o <= 1'b0;
            code_rd_req_addr_o  <= '0;
            code_rd_req_wid_o   <= '0;
        end else if (can_grant) begin
            code_rd_req_valid_o <= 1'b1;
            code_rd_req_addr_o  <= win_addr;
            code_rd_req_wid_o   <= arb_idx;
        end else if (req_xfer) begin
            code_rd_req_valid_o <= 1'b0;
        end
    end

    // Response steering, one cycle of latency; addr/data hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_rsp_valid_o <= '0;
            fetch_rsp_addr_o  <= '0;
            fetch_rsp_data_o  <= '0;
        end else begin
            fetch_rsp_valid_o <= rsp_deliver ? rsp_onehot : '0;
            if (rsp_deliver) begin
                fetch_rsp_addr_o <= code_rd_rsp_addr_i;
                fetch_rsp_data_o <= code_rd_rsp_data_i;
            end
        end
    end

`ifdef CODE_FETCH_CHECK_EN
    logic [ADDR_W-1:0] addr_tab [NUM_WARP];
    logic              stall_q;
    logic [ADDR_W-1:0] stall_addr_q;
    wid_t              stall_wid_q;
    logic              err_spurious;
    logic              err_addr;
    logic              err_hold;

    // NOTE: the address table has no reset; an entry is only read while its
    // pending bit is set, and that bit is only set by the grant that writes it.
    always_ff @(posedge clk) begin
        if (can_grant) begin
            addr_tab[arb_idx] <= win_addr;
        end
    end

    assign err_spurious = code_rd_rsp_valid_i & ~pending[code_rd_rsp_wid_i];
    assign err_addr     = rsp_hit & (addr_tab[code_rd_rsp_wid_i] != code_rd_rsp_addr_i);
    assign err_hold     = stall_q & (~code_rd_req_valid_o |
                                     (code_rd_req_addr_o != stall_addr_q) |
                                     (code_rd_req_wid_o  != stall_wid_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q      <= 1'b0;
            stall_addr_q <= '0;
            stall_wid_q  <= '0;
            fetch_err_o  <= 1'b0;
        end else begin
            stall_q      <= code_rd_req_valid_o & ~code_mem_ready_i;
            stall_addr_q <= code_rd_req_addr_o;
            stall_wid_q  <= code_rd_req_wid_o;
            if (err_spurious || err_addr || err_hold) begin
                fetch_err_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_code_fetch_arb.sv
// -----------------------------------------------------------------------------
// tb_code_fetch_arb
//   Directed bench for code_fetch_arb (default MAX_OUTSTANDING = 4, 8 warps).
//   Expected read requests and warp responses are queued when stimulus is
//   issued; two monitors pop and compare whenever the DUT presents a memory
//   transfer or a warp response. Grant vectors and latencies are checked
//   inline against hand-computed values.
// -----------------------------------------------------------------------------
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`ifndef CODE_MEM_ADDR_WIDTH
`define CODE_MEM_ADDR_WIDTH 32
`endif
`ifndef CODE_MEM_DATA_WIDTH
`define CODE_MEM_DATA_WIDTH 32
`endif

module tb_code_fetch_arb;
    import code_fetch_arb_pkg::*;

    localparam int NW = DEF_NUM_WARP;
    localparam int AW = `CODE_MEM_ADDR_WIDTH;
    localparam int DW = `CODE_MEM_DATA_WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NW-1:0]    fetch_req_valid_i;
    logic [NW*AW-1:0] fetch_req_addr_i;
    logic [NW-1:0]    fetch_req_ready_o;
    logic [NW-1:0]    flush_i;
    logic             code_mem_ready_i;
    logic             code_rd_req_valid_o;
    logic [AW-1:0]    code_rd_req_addr_o;
    wid_t             code_rd_req_wid_o;
    logic             code_rd_rsp_valid_i;
    logic [AW-1:0]    code_rd_rsp_addr_i;
    wid_t             code_rd_rsp_wid_i;
    logic [DW-1:0]    code_rd_rsp_data_i;
    logic [NW-1:0]    fetch_rsp_valid_o;
    logic [AW-1:0]    fetch_rsp_addr_o;
    logic [DW-1:0]    fetch_rsp_data_o;
`ifdef CODE_FETCH_CHECK_EN
    logic             fetch_err_o;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        wid_t          wid;
    } req_t;

    typedef struct {
        logic [NW-1:0] vec;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rsp_t;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];
    req_t mon_req;
    rsp_t mon_rsp;

    int n_checks = 0;
    int n_fail   = 0;

    code_fetch_arb dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fetch_req_valid_i   (fetch_req_valid_i),
        .fetch_req_addr_i    (fetch_req_addr_i),
        .fetch_req_ready_o   (fetch_req_ready_o),
        .flush_i             (flush_i),
        .code_mem_ready_i    (code_mem_ready_i),
        .code_rd_req_valid_o (code_rd_req_valid_o),
        .code_rd_req_addr_o  (code_rd_req_addr_o),
        .code_rd_req_wid_o   (code_rd_req_wid_o),
        .code_rd_rsp_valid_i (code_rd_rsp_valid_i),
        .code_rd_rsp_addr_i  (code_rd_rsp_addr_i),
        .code_rd_rsp_wid_i   (code_rd_rsp_wid_i),
        .code_rd_rsp_data_i  (code_rd_rsp_data_i),
`ifdef CODE_FETCH_CHECK_EN
        .fetch_err_o         (fetch_err_o),
`endif
        .fetch_rsp_valid_o   (fetch_rsp_valid_o),
        .fetch_rsp_addr_o    (fetch_rsp_addr_o),
        .fetch_rsp_data_o    (fetch_rsp_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 2ns after the rising edge; monitors sample on the falling edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_addr(input int w, input logic [AW-1:0] a);
        fetch_req_addr_i[w*AW +: AW] = a;
    endtask

    // Checks the combinational grant for the current inputs and queues the
    // memory read each granted warp is expected to issue.
    task automatic expect_grant(input string name, input logic [NW-1:0] exp, input bit push = 1'b1);
        #1;
        check(name, fetch_req_ready_o, exp);
        if (push) begin
            for (int w = 0; w < NW; w++) begin
                if (exp[w]) begin
                    exp_req_q.push_back('{addr: fetch_req_addr_i[w*AW +: AW], wid: wid_t'(w)});
                end
            end
        end
    endtask

    task automatic drive_rsp(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input bit deliver);
        code_rd_rsp_valid_i = 1'b1;
        code_rd_rsp_wid_i   = wid_t'(w);
        code_rd_rsp_addr_i  = a;
        code_rd_rsp_data_i  = d;
        if (deliver) begin
            exp_rsp_q.push_back('{vec: NW'(1) << w, addr: a, data: d});
        end
    endtask

    // Called right after the edge that consumed the response: the pulse must
    // already be visible (latency 1) or absent when discarded.
    task automatic end_rsp(input int w, input bit deliver);
        logic [NW-1:0] exp_vec;
        code_rd_rsp_valid_i = 1'b0;
        exp_vec = deliver ? (NW'(1) << w) : '0;
        #1;
        check("rsp_latency1", fetch_rsp_valid_o, exp_vec);
    endtask

    task automatic rsp_cycle(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input bit deliver);
        drive_rsp(w, a, d, deliver);
        tick();
        end_rsp(w, deliver);
    endtask

    // Memory-side monitor: every transfer must match the next queued grant.
    always @(negedge clk) begin
        if (rst_n && code_rd_req_valid_o && code_mem_ready_i) begin
            if (exp_req_q.size() == 0) begin
                check("req_unexpected_xfer", code_rd_req_valid_o, 0);
            end else begin
                mon_req = exp_req_q.pop_front();
                check("req_addr", code_rd_req_addr_o, mon_req.addr);
                check("req_wid", code_rd_req_wid_o, mon_req.wid);
            end
        end
    end

    // Warp-side monitor: every response pulse must match the next queued one.
    always @(negedge clk) begin
        if (rst_n && (fetch_rsp_valid_o != '0)) begin
            if (exp_rsp_q.size() == 0) begin
                check("rsp_unexpected_pulse", fetch_rsp_valid_o, 0);
            end else begin
                mon_rsp = exp_rsp_q.pop_front();
                check("rsp_vec", fetch_rsp_valid_o, mon_rsp.vec);
                check("rsp_addr", fetch_rsp_addr_o, mon_rsp.addr);
                check("rsp_data", fetch_rsp_data_o, mon_rsp.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n               = 1'b0;
        fetch_req_valid_i   = '0;
        fetch_req_addr_i    = '0;
        flush_i             = '0;
        code_mem_ready_i    = 1'b0;
        code_rd_rsp_valid_i = 1'b0;
        code_rd_rsp_wid_i   = '0;
        code_rd_rsp_addr_i  = '0;
        code_rd_rsp_data_i  = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rst_ready", fetch_req_ready_o, 0);
        check("rst_req_valid", code_rd_req_valid_o, 0);
        check("rst_req_addr", code_rd_req_addr_o, 0);
        check("rst_req_wid", code_rd_req_wid_o, 0);
        check("rst_rsp_valid", fetch_rsp_valid_o, 0);
        check("rst_rsp_data", fetch_rsp_data_o, 0);
`ifdef CODE_FETCH_CHECK_EN
        check("rst_err", fetch_err_o, 0);
`endif
        tick();

        // All warps request, memory ready, no responses: w0..w3 one per cycle, then the cap holds.
        code_mem_ready_i = 1'b1;
        for (int w = 0; w < NW; w++) set_addr(w, AW'(32'h1000 + w * 4));
        fetch_req_valid_i = '1;
        for (int i = 0; i < 6; i++) begin
            expect_grant("cap_fill", (i < 4) ? (NW'(1) << i) : '0);
            tick();
        end

        // One response frees a slot, but only from the following cycle.
        drive_rsp(1, 'h1004, 'hA000_0001, 1'b1);
        expect_grant("no_same_cycle_bypass", '0);
        tick();
        end_rsp(1, 1'b1);
        expect_grant("grant_after_rsp", 8'h10);
        tick();
        expect_grant("cap_refilled", '0);
        fetch_req_valid_i = '0;
        rsp_cycle(0, 'h1000, 'hA000_0000, 1'b1);
        rsp_cycle(2, 'h1008, 'hA000_0002, 1'b1);
        rsp_cycle(3, 'h100C, 'hA000_0003, 1'b1);
        rsp_cycle(4, 'h1010, 'hA000_0004, 1'b1);

        // Move the pointer to 3 (grant w2), then w2+w5 request: w5 first, w2 after the wrap.
        set_addr(2, 'h200);
        fetch_req_valid_i = 8'h04;
        expect_grant("ptr_to_3", 8'h04);
        tick();
        fetch_req_valid_i = '0;
        tick();
        rsp_cycle(2, 'h200, 'hB000_0200, 1'b1);
        set_addr(2, 'h204);
        set_addr(5, 'h500);
        fetch_req_valid_i = 8'h24;
        expect_grant("ptr3_first_w5", 8'h20);
        tick();
        expect_grant("ptr3_wrap_w2", 8'h04);
        tick();
        expect_grant("ptr3_both_pending", '0);
        fetch_req_valid_i = '0;
        rsp_cycle(2, 'h204, 'hB000_0204, 1'b1);
        rsp_cycle(5, 'h500, 'hB000_0500, 1'b1);

        // Backpressure: request for w3 at 0x40 held for 5 cycles, w6 waits on the full register.
        code_mem_ready_i = 1'b0;
        set_addr(3, 'h40);
        fetch_req_valid_i = 8'h08;
        expect_grant("stall_grant_w3", 8'h08);
        tick();
        set_addr(6, 'h600);
        fetch_req_valid_i = 8'h40;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", code_rd_req_valid_o, 1);
            check("stall_addr", code_rd_req_addr_o, 'h40);
            check("stall_wid", code_rd_req_wid_o, 3);
            check("stall_no_grant", fetch_req_ready_o, 0);
            tick();
        end
        code_mem_ready_i = 1'b1;
        expect_grant("grant_while_xfer", 8'h40);
        tick();
        fetch_req_valid_i = '0;
        tick();
        rsp_cycle(3, 'h40, 'hC000_0040, 1'b1);
        rsp_cycle(6, 'h600, 'hC000_0600, 1'b1);

        // Flush after grant: response discarded, outputs hold, warp 1 grantable next cycle.
        set_addr(1, 'h100);
        fetch_req_valid_i = 8'h02;
        expect_grant("flush_grant_w1", 8'h02);
        tick();
        fetch_req_valid_i = '0;
        flush_i = 8'h02;
        tick();
        flush_i = '0;
        tick();
        drive_rsp(1, 'h100, 'hDEAD_BEEF, 1'b0);
        set_addr(1, 'h104);
        fetch_req_valid_i = 8'h02;
        expect_grant("flushed_still_pending", '0);
        tick();
        end_rsp(1, 1'b0);
        check("hold_rsp_addr", fetch_rsp_addr_o, 'h600);
        check("hold_rsp_data", fetch_rsp_data_o, 'hC000_0600);
        expect_grant("regrant_after_drop", 8'h02);
        tick();
        fetch_req_valid_i = '0;
        tick();
        rsp_cycle(1, 'h104, 'hD000_0104, 1'b1);

        // Flush while the request is still held in the register: not withdrawn, response dropped.
        code_mem_ready_i = 1'b0;
        set_addr(7, 'h700);
        fetch_req_valid_i = 8'h80;
        expect_grant("held_grant_w7", 8'h80);
        tick();
        fetch_req_valid_i = '0;
        flush_i = 8'h80;
        #1 check("flush_not_withdrawn", code_rd_req_valid_o, 1);
        tick();
        flush_i = '0;
        code_mem_ready_i = 1'b1;
        tick();
        rsp_cycle(7, 'h700, 'hE000_0700, 1'b0);

        // Flush on an idle warp blocks only that cycle and leaves no drop behind.
        set_addr(0, 'h80);
        fetch_req_valid_i = 8'h01;
        flush_i = 8'h01;
        expect_grant("flush_blocks_eligible", '0);
        tick();
        flush_i = '0;
        expect_grant("idle_flush_no_effect", 8'h01);
        tick();
        fetch_req_valid_i = '0;
        tick();

        // Spurious response (w6 idle) with one read in flight: count must stay 1 -> 3 more grants.
        rsp_cycle(6, 'h600, 'hF000_0006, 1'b0);
`ifdef CODE_FETCH_CHECK_EN
        check("err_on_spurious", fetch_err_o, 1);
`endif
        for (int w = 1; w < 4; w++) set_addr(w, AW'(32'h2000 + w * 4));
        fetch_req_valid_i = '1;
        expect_grant("spur_g1", 8'h02);
        tick();
        expect_grant("spur_g2", 8'h04);
        tick();
        expect_grant("spur_g3", 8'h08);
        tick();
        expect_grant("spur_cap", '0);
        tick();
        expect_grant("spur_cap_hold", '0);
        fetch_req_valid_i = '0;
        // Flush arriving together with the response also discards it.
        drive_rsp(0, 'h80, 'hF000_0080, 1'b0);
        flush_i = 8'h01;
        tick();
        flush_i = '0;
        end_rsp(0, 1'b0);
        rsp_cycle(1, 'h2004, 'hF000_2004, 1'b1);
        rsp_cycle(2, 'h2008, 'hF000_2008, 1'b1);
        rsp_cycle(3, 'h200C, 'hF000_200C, 1'b1);
`ifdef CODE_FETCH_CHECK_EN
        check("err_sticky", fetch_err_o, 1);
`endif

        // Reset mid-operation with w5's request held: everything clears, late response is spurious.
        code_mem_ready_i = 1'b0;
        set_addr(5, 'h5A0);
        fetch_req_valid_i = 8'h20;
        expect_grant("pre_reset_grant", 8'h20, 1'b0);
        tick();
        fetch_req_valid_i = '0;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_req_valid", code_rd_req_valid_o, 0);
        check("async_rst_rsp_addr", fetch_rsp_addr_o, 0);
`ifdef CODE_FETCH_CHECK_EN
        check("async_rst_err", fetch_err_o, 0);
`endif
        tick();
        rst_n = 1'b1;
        code_mem_ready_i = 1'b1;
        rsp_cycle(5, 'h5A0, 'h0000_00AA, 1'b0);
        set_addr(6, 'h6A0);
        fetch_req_valid_i = 8'h60;
        expect_grant("ptr_cleared_by_reset", 8'h20);
        tick();
        fetch_req_valid_i = '0;
        tick();
        rsp_cycle(5, 'h5A0, 'h0000_55AA, 1'b1);

        repeat (3) tick();
        check("req_queue_drained", exp_req_q.size(), 0);
        check("rsp_queue_drained", exp_rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
